decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 16-bit pipelined core; sits directly upstream of Execute.
- Takes fetched instruction plus next-PC, splits fields, reads the 8x16 register file, and sign-/zero-extends immediates.
- Registers everything into the ID/EX pipeline register that drives Execute's control / source_reg / dest_reg / npc inputs.
- Owns load-use interlock (one-cycle stall plus bubble) and honours branch flush from Execute.

Parameters:
- NREGS, 8, architectural register count (index width = 3).
- DW, 16, data/instruction/PC width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  16  instruction word.
- if_npc  in  16  PC+1 of that instruction.
- ex_flush  in  1  taken jump/branch resolved in Execute; kill younger instructions.
- wb_we  in  1  writeback register write enable.
- wb_idx  in  3  writeback register index.
- wb_data  in  16  writeback data.
- stall  out  1  combinational; fetch must hold PC and if_instr this cycle.
- id_valid  out  1  ID/EX slot holds a real instruction.
- id_control  out  5  opcode to Execute.
- id_source  out  16  RF[rs] value.
- id_dest  out  16  RF[rd] value.
- id_imm  out  16  extended immediate.
- id_npc  out  16  registered if_npc.
- id_rd_idx  out  3  destination index.
- id_wr_en  out  1  instruction writes a register.
- id_illegal  out  1  opcode > 5'b10000 was decoded (one cycle, with valid=0).

Behaviour:
- Format: op=[15:11], rd=[10:8], rs=[7:5], imm5=[4:0]; jump ops (JUMP..JUMPNE) use off11=[10:0].
- Opcodes: ADD 0, SUB 1, ADDI 2, SHLLI 3, SHRLI 4, JUMP 5, JUMPLI 6, JUMPL 7, JUMPG 8, JUMPE 9, JUMPNE 10, CMP 11, RET 12, LOAD 13, LOADI 14, STORE 15, MOV 16.
- id_imm:
  - ADDI and LOAD: sign-extend imm5.
  - SHLLI, SHRLI, LOADI: zero-extend imm5.
  - Jump ops: sign-extend off11.
  - All other ops: 0.
- uses_rs: ADD, SUB, ADDI, SHLLI, SHRLI, CMP, LOAD, STORE.
- uses_rd: ADD, SUB, CMP, STORE, MOV, RET.
- id_wr_en=1 for ADD, SUB, ADDI, SHLLI, SHRLI, LOAD, LOADI, MOV; otherwise 0.
- Register file: 8x16 flops, no hardwired zero register.
  - Write on posedge when wb_we.
  - Reads are combinational with write-through bypass: if wb_we && wb_idx==rs (rd), the read returns wb_data.
- Latency: one cycle. Decode of if_instr at edge N appears on id_* after edge N.
- Load-use hazard, combinational:
  - stall = id_valid && id_control==LOAD && if_valid && !ex_flush && ((uses_rs && rs==id_rd_idx) || (uses_rd && rd==id_rd_idx)).
  - On a stall edge the ID/EX register loads a bubble and if_instr is not consumed.
  - A stall lasts exactly one cycle: the bubble clears the LOAD from ID/EX.
- Bubble definition: id_valid=0, id_control=ADD, id_wr_en=0, id_rd_idx=0, id_imm=0, id_illegal=0. Data fields hold don't-care but are driven 0.
- Edge priority:
  1. ex_flush: load bubble, stall forced 0.
  2. stall: load bubble.
  3. if_valid=0: load bubble.
  4. Illegal opcode: load bubble with id_illegal=1.
  5. Otherwise: load decoded instruction, id_valid=1.
- A wb write in the same cycle as a stall is still performed. The re-decode next cycle sees the updated RF.
- Reset (async, any time including mid-stall): all id_* outputs go to bubble values, id_npc=0, all 8 registers=0. stall is combinational and becomes 0 because id_valid=0.
- No back-pressure from Execute; Execute accepts every cycle.

Decomposition:
- Shared package core_pkg holds:
  - the 5-bit opcode constants, also used by Execute;
  - instruction field bit positions;
  - the bubble default values.
- One natural sub-module: regfile_8x16 (async reset, 1 write port, 2 read ports with write-through bypass).
- Decode tables (uses_rs, uses_rd, wr_en, imm select) stay in decode_stage.

Test Plan:
- Reset: assert rst mid-run with a pending LOAD hazard -> immediately id_valid=0, stall=0, id_npc=0; after release, every register reads 0.
- ADD decode: RF[2]=0x0005, RF[3]=0x0007; if_instr=0x0360 (ADD rd=3, rs=3) with npc=0x0011 -> next edge id_control=0, id_source=id_dest=0x0007, id_rd_idx=3, id_wr_en=1, id_npc=0x0011.
- Bypass: wb_we=1, wb_idx=2, wb_data=0xBEEF in the same cycle as ADDI rs=2, imm5=5'b11111 -> id_source=0xBEEF, id_imm=0xFFFF.
- Load-use: LOAD rd=4 followed by ADD with rs=4 -> stall=1 for exactly one cycle, one bubble, then ADD issues with id_valid=1; a following ADD with rs=5 does not stall.
- Flush: ex_flush=1 during the stall cycle -> stall=0, bubble loaded, fetch advances.
- Jump/illegal: JUMP off11=0x7FF -> id_imm=0xFFFF, id_wr_en=0; opcode 5'b11111 -> id_valid=0, id_illegal=1 for one cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, instruction field positions and ID/EX bubble values.
// Execute imports the same opcode constants.
package core_pkg;

    localparam int DW    = 16;
    localparam int NREGS = 8;
    localparam int RIW   = 3;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_ADDI   = 5'd2;
    localparam logic [4:0] OP_SHLLI  = 5'd3;
    localparam logic [4:0] OP_SHRLI  = 5'd4;
    localparam logic [4:0] OP_JUMP   = 5'd5;
    localparam logic [4:0] OP_JUMPLI = 5'd6;
    localparam logic [4:0] OP_JUMPL  = 5'd7;
    localparam logic [4:0] OP_JUMPG  = 5'd8;
    localparam logic [4:0] OP_JUMPE  = 5'd9;
    localparam logic [4:0] OP_JUMPNE = 5'd10;
    localparam logic [4:0] OP_CMP    = 5'd11;
    localparam logic [4:0] OP_RET    = 5'd12;
    localparam logic [4:0] OP_LOAD   = 5'd13;
    localparam logic [4:0] OP_LOADI  = 5'd14;
    localparam logic [4:0] OP_STORE  = 5'd15;
    localparam logic [4:0] OP_MOV    = 5'd16;
    localparam logic [4:0] OP_MAX    = OP_MOV;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 5;
    localparam int IMM_MSB = 4;
    localparam int OFF_MSB = 10;

    typedef struct packed {
        logic           valid;
        logic [4:0]     control;
        logic [DW-1:0]  source;
        logic [DW-1:0]  dest;
        logic [DW-1:0]  imm;
        logic [DW-1:0]  npc;
        logic [RIW-1:0] rd_idx;
        logic           wr_en;
        logic           illegal;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:   1'b0,
        control: OP_ADD,
        source:  '0,
        dest:    '0,
        imm:     '0,
        npc:     '0,
        rd_idx:  '0,
        wr_en:   1'b0,
        illegal: 1'b0
    };

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback/flush inputs and ID/EX outputs of the decode stage.
interface decode_stage_if;
    import core_pkg::*;

    logic           if_valid;
    logic [DW-1:0]  if_instr;
    logic [DW-1:0]  if_npc;
    logic           ex_flush;
    logic           wb_we;
    logic [RIW-1:0] wb_idx;
    logic [DW-1:0]  wb_data;
    logic           stall;
    logic           id_valid;
    logic [4:0]     id_control;
    logic [DW-1:0]  id_source;
    logic [DW-1:0]  id_dest;
    logic [DW-1:0]  id_imm;
    logic [DW-1:0]  id_npc;
    logic [RIW-1:0] id_rd_idx;
    logic           id_wr_en;
    logic           id_illegal;

    modport master (
        output if_valid, if_instr, if_npc, ex_flush, wb_we, wb_idx, wb_data,
        input  stall, id_valid, id_control, id_source, id_dest, id_imm, id_npc,
               id_rd_idx, id_wr_en, id_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_npc, ex_flush, wb_we, wb_idx, wb_data,
        output stall, id_valid, id_control, id_source, id_dest, id_imm, id_npc,
               id_rd_idx, id_wr_en, id_illegal
    );
endinterface

// File: rtl/regfile_8x16.sv
// 8x16 flop register file, one write port, two combinational read ports.
// A same-cycle write is forwarded to the readers.
module regfile_8x16
    import core_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           we_i,
    input  logic [RIW-1:0] widx_i,
    input  logic [DW-1:0]  wdata_i,
    input  logic [RIW-1:0] ra_i,
    input  logic [RIW-1:0] rb_i,
    output logic [DW-1:0]  ra_data_o,
    output logic [DW-1:0]  rb_data_o
);

    logic [DW-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[widx_i] <= wdata_i;
        end
    end

    assign ra_data_o = (we_i && widx_i == ra_i) ? wdata_i : regs_q[ra_i];
    assign rb_data_o = (we_i && widx_i == rb_i) ? wdata_i : regs_q[rb_i];

endmodule

// File: rtl/decode_stage.sv
// ID stage: field split, register read, immediate extension and ID/EX register.
// Owns the one-cycle load-use interlock and honours Execute's flush.
module decode_stage
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    decode_stage_if.slave bus
);

    logic [4:0]     op;
    logic [RIW-1:0] rd, rs;
    logic [4:0]     imm5;
    logic [10:0]    off11;
    logic [DW-1:0]  rs_data, rd_data;

    logic           uses_rs, uses_rd, wr_en, illegal, stall;
    logic [DW-1:0]  imm;
    id_ex_t         id_ex_d, id_ex_q;

    assign op    = bus.if_instr[OP_MSB:OP_LSB];
    assign rd    = bus.if_instr[RD_MSB:RD_LSB];
    assign rs    = bus.if_instr[RS_MSB:RS_LSB];
    assign imm5  = bus.if_instr[IMM_MSB:0];
    assign off11 = bus.if_instr[OFF_MSB:0];

    regfile_8x16 u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (bus.wb_we),
        .widx_i    (bus.wb_idx),
        .wdata_i   (bus.wb_data),
        .ra_i      (rs),
        .rb_i      (rd),
        .ra_data_o (rs_data),
        .rb_data_o (rd_data)
    );

    always_comb begin
        uses_rs = 1'b0;
        uses_rd = 1'b0;
        wr_en   = 1'b0;
        imm     = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                wr_en   = 1'b1;
            end
            OP_ADDI, OP_LOAD: begin
                uses_rs = 1'b1;
                wr_en   = 1'b1;
                imm     = {{(DW-5){imm5[4]}}, imm5};
            end
            OP_SHLLI, OP_SHRLI: begin
                uses_rs = 1'b1;
                wr_en   = 1'b1;
                imm     = {{(DW-5){1'b0}}, imm5};
            end
            OP_JUMP, OP_JUMPLI, OP_JUMPL, OP_JUMPG, OP_JUMPE, OP_JUMPNE: begin
                imm = {{(DW-11){off11[10]}}, off11};
            end
            OP_CMP, OP_STORE: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
            end
            OP_RET: uses_rd = 1'b1;
            OP_LOADI: begin
                wr_en = 1'b1;
                imm   = {{(DW-5){1'b0}}, imm5};
            end
            OP_MOV: begin
                uses_rd = 1'b1;
                wr_en   = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = (op > OP_MAX);

    // Only a LOAD sitting in ID/EX can create a hazard; the bubble it leaves clears the stall.
    assign stall = id_ex_q.valid && (id_ex_q.control == OP_LOAD) && bus.if_valid &&
                   !bus.ex_flush &&
                   ((uses_rs && rs == id_ex_q.rd_idx) || (uses_rd && rd == id_ex_q.rd_idx));

    always_comb begin
        id_ex_d = ID_EX_BUBBLE;
        if (bus.ex_flush || stall || !bus.if_valid) begin
            id_ex_d = ID_EX_BUBBLE;
        end else if (illegal) begin
            id_ex_d.illegal = 1'b1;
        end else begin
            id_ex_d.valid   = 1'b1;
            id_ex_d.control = op;
            id_ex_d.source  = rs_data;
            id_ex_d.dest    = rd_data;
            id_ex_d.imm     = imm;
            id_ex_d.npc     = bus.if_npc;
            id_ex_d.rd_idx  = rd;
            id_ex_d.wr_en   = wr_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) id_ex_q <= ID_EX_BUBBLE;
        else     id_ex_q <= id_ex_d;
    end

    assign bus.stall      = stall;
    assign bus.id_valid   = id_ex_q.valid;
    assign bus.id_control = id_ex_q.control;
    assign bus.id_source  = id_ex_q.source;
    assign bus.id_dest    = id_ex_q.dest;
    assign bus.id_imm     = id_ex_q.imm;
    assign bus.id_npc     = id_ex_q.npc;
    assign bus.id_rd_idx  = id_ex_q.rd_idx;
    assign bus.id_wr_en   = id_ex_q.wr_en;
    assign bus.id_illegal = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, bypass, load-use interlock, flush, jumps, illegal, reset.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [4:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
        bus.if_instr = 16'h0;
        bus.ex_flush = 1'b0;
        bus.wb_we    = 1'b0;
    endtask

    task automatic issue(input logic [15:0] instr, input logic [15:0] npc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_npc   = npc;
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [15:0] data);
        idle();
        bus.wb_we   = 1'b1;
        bus.wb_idx  = idx;
        bus.wb_data = data;
        step();
        bus.wb_we = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", bus.id_valid); end
        total++; if (bus.id_npc !== 16'h0) begin bad++; $display("FAIL reset_npc got=%0h want=0", bus.id_npc); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h want=0", bus.stall); end
        #12 rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        wb_write(3'd2, 16'h0005);
        wb_write(3'd3, 16'h0007);
        issue(16'h0360, 16'h0011);
        step();
        total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0h want=1", bus.id_valid); end
        total++; if (bus.id_control !== 5'd0) begin bad++; $display("FAIL add_control got=%0h want=0", bus.id_control); end
        total++; if (bus.id_source !== 16'h0007) begin bad++; $display("FAIL add_source got=%0h want=7", bus.id_source); end
        total++; if (bus.id_dest !== 16'h0007) begin bad++; $display("FAIL add_dest got=%0h want=7", bus.id_dest); end
        total++; if (bus.id_rd_idx !== 3'd3) begin bad++; $display("FAIL add_rd got=%0h want=3", bus.id_rd_idx); end
        total++; if (bus.id_wr_en !== 1'b1) begin bad++; $display("FAIL add_wren got=%0h want=1", bus.id_wr_en); end
        total++; if (bus.id_npc !== 16'h0011) begin bad++; $display("FAIL add_npc got=%0h want=11", bus.id_npc); end
        total++; if (bus.id_imm !== 16'h0000) begin bad++; $display("FAIL add_imm got=%0h want=0", bus.id_imm); end
        // SUB rd=2 rs=3 reads 5 on the dest port
        issue(enc(5'd1, 3'd2, 3'd3, 5'd0), 16'h0012);
        step();
        total++; if (bus.id_dest !== 16'h0005) begin bad++; $display("FAIL sub_dest got=%0h want=5", bus.id_dest); end
    endtask

    task automatic test_bypass();
        issue(enc(5'd2, 3'd1, 3'd2, 5'h1F), 16'h0020);
        bus.wb_we   = 1'b1;
        bus.wb_idx  = 3'd2;
        bus.wb_data = 16'hBEEF;
        step();
        bus.wb_we = 1'b0;
        total++; if (bus.id_source !== 16'hBEEF) begin bad++; $display("FAIL bypass_source got=%0h want=beef", bus.id_source); end
        total++; if (bus.id_imm !== 16'hFFFF) begin bad++; $display("FAIL addi_imm got=%0h want=ffff", bus.id_imm); end
        total++; if (bus.id_wr_en !== 1'b1) begin bad++; $display("FAIL addi_wren got=%0h want=1", bus.id_wr_en); end
        // the write landed: plain read of r2 now returns it
        issue(enc(5'd16, 3'd2, 3'd0, 5'd0), 16'h0021);
        step();
        total++; if (bus.id_dest !== 16'hBEEF) begin bad++; $display("FAIL rf_written got=%0h want=beef", bus.id_dest); end
    endtask

    task automatic test_imm_ext();
        issue(enc(5'd4, 3'd1, 3'd2, 5'h1F), 16'h0030);
        step();
        total++; if (bus.id_imm !== 16'h001F) begin bad++; $display("FAIL shrli_imm got=%0h want=1f", bus.id_imm); end
        issue(enc(5'd14, 3'd1, 3'd0, 5'h10), 16'h0031);
        step();
        total++; if (bus.id_imm !== 16'h0010) begin bad++; $display("FAIL loadi_imm got=%0h want=10", bus.id_imm); end
        issue(enc(5'd13, 3'd1, 3'd0, 5'h10), 16'h0032);
        step();
        total++; if (bus.id_imm !== 16'hFFF0) begin bad++; $display("FAIL load_imm got=%0h want=fff0", bus.id_imm); end
        issue(enc(5'd11, 3'd1, 3'd0, 5'h1F), 16'h0033);
        step();
        total++; if (bus.id_imm !== 16'h0000 || bus.id_wr_en !== 1'b0) begin bad++; $display("FAIL cmp_imm_wren got=%0h/%0h want=0/0", bus.id_imm, bus.id_wr_en); end
        idle();
        step();
    endtask

    task automatic test_load_use();
        issue(enc(5'd13, 3'd4, 3'd0, 5'd0), 16'h0040);
        step();
        issue(enc(5'd0, 3'd1, 3'd4, 5'd0), 16'h0041);
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h want=1", bus.stall); end
        step();
        total++; if (bus.id_valid !== 1'b0 || bus.id_control !== 5'd0) begin bad++; $display("FAIL lu_bubble got=%0h/%0h want=0/0", bus.id_valid, bus.id_control); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%0h want=0", bus.stall); end
        step();
        total++; if (bus.id_valid !== 1'b1 || bus.id_rd_idx !== 3'd1 || bus.id_npc !== 16'h0041) begin bad++; $display("FAIL lu_issue got=%0h/%0h/%0h want=1/1/41", bus.id_valid, bus.id_rd_idx, bus.id_npc); end
        // STORE reading r4 through its rd field also interlocks
        issue(enc(5'd13, 3'd4, 3'd0, 5'd0), 16'h0042);
        step();
        issue(enc(5'd15, 3'd4, 3'd0, 5'd0), 16'h0043);
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_rd_stall got=%0h want=1", bus.stall); end
        step();
        step();
        issue(enc(5'd13, 3'd4, 3'd0, 5'd0), 16'h0044);
        step();
        issue(enc(5'd0, 3'd1, 3'd5, 5'd0), 16'h0045);
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_nohaz got=%0h want=0", bus.stall); end
        step();
        total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL lu_nohaz_issue got=%0h want=1", bus.id_valid); end
    endtask

    task automatic test_flush();
        issue(enc(5'd13, 3'd4, 3'd0, 5'd0), 16'h0050);
        step();
        issue(enc(5'd0, 3'd1, 3'd4, 5'd0), 16'h0051);
        bus.ex_flush = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0h want=0", bus.stall); end
        step();
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%0h want=0", bus.id_valid); end
        bus.ex_flush = 1'b0;
        issue(enc(5'd16, 3'd6, 3'd0, 5'd0), 16'h0060);
        step();
        total++; if (bus.id_valid !== 1'b1 || bus.id_control !== 5'd16 || bus.id_npc !== 16'h0060) begin bad++; $display("FAIL flush_advance got=%0h/%0h/%0h want=1/10/60", bus.id_valid, bus.id_control, bus.id_npc); end
    endtask

    task automatic test_jump_illegal();
        issue(16'h2FFF, 16'h0070);
        step();
        total++; if (bus.id_imm !== 16'hFFFF || bus.id_wr_en !== 1'b0 || bus.id_control !== 5'd5) begin bad++; $display("FAIL jump_neg got=%0h/%0h/%0h want=ffff/0/5", bus.id_imm, bus.id_wr_en, bus.id_control); end
        issue({5'd10, 11'h3FF}, 16'h0071);
        step();
        total++; if (bus.id_imm !== 16'h03FF) begin bad++; $display("FAIL jump_pos got=%0h want=3ff", bus.id_imm); end
        issue(16'hF800, 16'h0072);
        step();
        total++; if (bus.id_valid !== 1'b0 || bus.id_illegal !== 1'b1) begin bad++; $display("FAIL illegal got=%0h/%0h want=0/1", bus.id_valid, bus.id_illegal); end
        issue({5'd17, 11'h0}, 16'h0073);
        step();
        total++; if (bus.id_illegal !== 1'b1) begin bad++; $display("FAIL illegal17 got=%0h want=1", bus.id_illegal); end
        idle();
        step();
        total++; if (bus.id_illegal !== 1'b0) begin bad++; $display("FAIL illegal_once got=%0h want=0", bus.id_illegal); end
    endtask

    task automatic test_reset_mid();
        wb_write(3'd5, 16'h1234);
        issue(enc(5'd13, 3'd4, 3'd0, 5'd0), 16'h0080);
        step();
        issue(enc(5'd0, 3'd1, 3'd4, 5'd0), 16'h0081);
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0h want=1", bus.stall); end
        rst = 1'b1;
        #1;
        total++; if (bus.id_valid !== 1'b0 || bus.stall !== 1'b0 || bus.id_npc !== 16'h0) begin bad++; $display("FAIL rstmid got=%0h/%0h/%0h want=0/0/0", bus.id_valid, bus.stall, bus.id_npc); end
        idle();
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(enc(5'd16, i[2:0], i[2:0], 5'd0), 16'h0090);
            step();
            total++; if (bus.id_dest !== 16'h0 || bus.id_source !== 16'h0) begin bad++; $display("FAIL rstmid_rf%0d got=%0h/%0h want=0/0", i, bus.id_dest, bus.id_source); end
        end
    endtask

    initial begin
        idle();
        bus.if_npc  = 16'h0;
        bus.wb_idx  = 3'd0;
        bus.wb_data = 16'h0;
        test_reset();
        test_add();
        test_bypass();
        test_imm_ext();
        test_load_use();
        test_flush();
        test_jump_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
